// File: rtl/mem_fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
// Latency: none; holds type and parameter definitions only.
// Backpressure: not applicable.
package mem_fetch_pkg;

    localparam int ADDR = 16;
    localparam int WORD = 32;

    typedef logic [ADDR-1:0] addr_t;
    typedef logic [WORD-1:0] word_t;

    localparam addr_t RESET_PC_DFLT = '0;

    // One queued fetch result: the instruction together with the address it came from.
    typedef struct packed {
        addr_t pc;
        word_t instr;
    } entry_t;

    // Sequential PC step; the addition wraps naturally at the top of the address space.
    function automatic addr_t pc_next(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/mem_fetch_if.sv
// Bundles the memory port, redirect input and decode handshake of the fetch unit.
// Latency: none; wiring only.
// Backpressure: out_ready from decode; the memory port has none.
interface mem_fetch_if;
    import mem_fetch_pkg::*;

    addr_t mem_a;
    logic  mem_w;
    word_t mem_d;
    word_t mem_q;
    logic  fetch_en;
    logic  redirect_valid;
    addr_t redirect_pc;
    logic  out_valid;
    logic  out_ready;
    word_t out_instr;
    addr_t out_pc;

    // Fetch unit side.
    modport master (
        output mem_a, mem_w, mem_d,
        input  mem_q,
        input  fetch_en, redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    // Memory, execute and decode side.
    modport slave (
        input  mem_a, mem_w, mem_d,
        output mem_q,
        output fetch_en, redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );

endinterface

// File: rtl/mem_fetch_fifo.sv
// Two-entry queue of {pc, instr} with a synchronous clear.
// Latency: an entry pushed at an edge is visible at the head from the next cycle.
// Backpressure: none internally; the caller must never push into a full queue.
module mem_fetch_fifo
    import mem_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_push,
    input  entry_t     i_push_dat,
    input  logic       i_pop,
    output logic [1:0] o_count,
    output entry_t     o_head_dat
);

    entry_t     r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    // Pointer and occupancy tracking; clear wins over any push or pop.
    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    // Storage needs no reset: the count says which slots hold live data.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    // The issue rule upstream leaves room for every in-flight word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst || i_clear)
        !(i_push && !i_pop && r_count == 2'd2));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst || i_clear)
        !(i_pop && r_count == 2'd0));

endmodule

// File: rtl/mem_fetch.sv
// Instruction fetch: issues one read per cycle from pc, queues {pc, instr}, redirectable.
// Latency: issue in cycle N, data captured at end of N+1, out_valid in N+2.
// Backpressure: out_ready stalls; issue stops once queued plus in-flight words reach two.
module mem_fetch
    import mem_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DFLT
)
(
    input  logic clk,
    input  logic rst,
    mem_fetch_if.master bus
);

    addr_t      r_pc;
    logic       r_inflight;
    addr_t      r_inflight_pc;

    logic [1:0] w_count;
    entry_t     w_head;
    entry_t     w_push_dat;
    logic       w_out_valid;
    logic       w_pop;
    logic       w_push;
    logic       w_issue;
    logic [2:0] w_occ;

    // Handshake and issue decisions; a redirect suppresses push, pop, issue and output.
    always_comb begin
        w_out_valid = (w_count != 2'd0) && !bus.redirect_valid;
        w_pop       = w_out_valid && bus.out_ready;
        w_push      = r_inflight && !bus.redirect_valid;
        w_occ       = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue     = bus.fetch_en && !bus.redirect_valid && (w_occ < 3'd2);
        w_push_dat  = '{pc: r_inflight_pc, instr: bus.mem_q};
    end

    // PC and in-flight tracking; a redirect drops the word still returning from memory.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            r_pc       <= bus.redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= pc_next(r_pc);
            end
        end
    end

    mem_fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (bus.redirect_valid),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_count    (w_count),
        .o_head_dat (w_head)
    );

    // Memory is read every cycle at pc; only issued cycles are tracked.
    assign bus.mem_a     = r_pc;
    assign bus.mem_w     = 1'b0;
    assign bus.mem_d     = '0;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;

endmodule

// File: tb/tb_mem_fetch.sv
// Directed bench for mem_fetch with a one-cycle-latency instruction memory model.
// Memory word i holds 0x1000_0000 + i.
// Inputs change #1 after a rising edge; outputs are sampled #2 after it.
module tb_mem_fetch;
    import mem_fetch_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    addr_t exp_head;

    mem_fetch_if bus ();

    mem_fetch #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: read data valid one cycle after the address.
    always @(posedge clk) begin
        if (!bus.mem_w) bus.mem_q <= 32'h1000_0000 + {16'h0000, bus.mem_a};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.fetch_en = 1'b1;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        tick(); tick(); settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.mem_a !== 16'h0000) $display("FAIL reset_mem_a got %h want 0000", bus.mem_a); else n_pass++;
        n_checks++; if (bus.mem_w !== 1'b0) $display("FAIL reset_mem_w got %b want 0", bus.mem_w); else n_pass++;
        n_checks++; if (bus.mem_d !== 32'h0) $display("FAIL reset_mem_d got %h want 0", bus.mem_d); else n_pass++;
    endtask

    // Release reset and stream with out_ready high: pc 0.. one per cycle, mem_a two ahead.
    task automatic test_stream();
        addr_t p;
        rst = 1'b1;
        tick(); settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL stream_early_valid got %b want 0", bus.out_valid); else n_pass++;
        tick(); settle();
        for (int i = 0; i < 6; i++) begin
            p = addr_t'(i);
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_pc !== p) $display("FAIL stream_pc[%0d] got %h want %h", i, bus.out_pc, p); else n_pass++;
            n_checks++; if (bus.out_instr !== 32'h1000_0000 + {16'h0, p}) $display("FAIL stream_instr[%0d] got %h want %h", i, bus.out_instr, 32'h1000_0000 + {16'h0, p}); else n_pass++;
            n_checks++; if (bus.mem_a !== p + 16'd2) $display("FAIL stream_mem_a[%0d] got %h want %h", i, bus.mem_a, p + 16'd2); else n_pass++;
            tick(); settle();
        end
        exp_head = 16'd6;
    endtask

    // Decode stalls for 5 cycles: head held, queue fills, pc stops two past the head.
    task automatic test_backpressure();
        addr_t h;
        addr_t p;
        h = exp_head;
        bus.out_ready = 1'b0;
        settle();
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", k, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_pc !== h) $display("FAIL bp_pc[%0d] got %h want %h", k, bus.out_pc, h); else n_pass++;
            n_checks++; if (bus.out_instr !== 32'h1000_0000 + {16'h0, h}) $display("FAIL bp_instr[%0d] got %h want %h", k, bus.out_instr, 32'h1000_0000 + {16'h0, h}); else n_pass++;
            n_checks++; if (bus.mem_a !== h + 16'd2) $display("FAIL bp_mem_a[%0d] got %h want %h", k, bus.mem_a, h + 16'd2); else n_pass++;
            tick(); settle();
        end
        bus.out_ready = 1'b1;
        settle();
        for (int i = 0; i < 6; i++) begin
            p = h + addr_t'(i);
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_resume_valid[%0d] got %b want 1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_pc !== p) $display("FAIL bp_resume_pc[%0d] got %h want %h", i, bus.out_pc, p); else n_pass++;
            tick(); settle();
        end
        exp_head = h + 16'd6;
    endtask

    // Redirect while a read is in flight and decode stalls: flushed, then 0x40.. delivered.
    task automatic test_redirect();
        addr_t p;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL redir_valid_same got %b want 0", bus.out_valid); else n_pass++;
        tick();
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL redir_valid_r1 got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.mem_a !== 16'h0040) $display("FAIL redir_mem_a got %h want 0040", bus.mem_a); else n_pass++;
        tick(); settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL redir_valid_r2 got %b want 0", bus.out_valid); else n_pass++;
        tick(); settle();
        for (int i = 0; i < 3; i++) begin
            p = 16'h0040 + addr_t'(i);
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL redir_out_valid[%0d] got %b want 1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_pc !== p) $display("FAIL redir_pc[%0d] got %h want %h", i, bus.out_pc, p); else n_pass++;
            n_checks++; if (bus.out_instr !== 32'h1000_0000 + {16'h0, p}) $display("FAIL redir_instr[%0d] got %h want %h", i, bus.out_instr, 32'h1000_0000 + {16'h0, p}); else n_pass++;
            tick(); settle();
        end
        exp_head = 16'h0043;
    endtask

    // Two redirects back to back: only the second target is fetched.
    task automatic test_redirect_b2b();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0080;
        tick();
        bus.redirect_pc = 16'h0020;
        settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_valid got %b want 0", bus.out_valid); else n_pass++;
        tick();
        bus.redirect_valid = 1'b0;
        settle();
        n_checks++; if (bus.mem_a !== 16'h0020) $display("FAIL b2b_mem_a got %h want 0020", bus.mem_a); else n_pass++;
        tick(); tick(); settle();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_out_valid got %b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_pc !== 16'h0020) $display("FAIL b2b_pc got %h want 0020", bus.out_pc); else n_pass++;
        tick(); tick(); settle();
        exp_head = 16'h0022;
    endtask

    // fetch_en low 3 cycles: the in-flight word still arrives, pc frozen, then resumes.
    task automatic test_fetch_en();
        addr_t h;
        addr_t p;
        h = exp_head;
        bus.fetch_en = 1'b0;
        settle();
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.mem_a !== h + 16'd2) $display("FAIL fen_mem_a[%0d] got %h want %h", k, bus.mem_a, h + 16'd2); else n_pass++;
            if (k < 2) begin
                p = h + addr_t'(k);
                n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL fen_valid[%0d] got %b want 1", k, bus.out_valid); else n_pass++;
                n_checks++; if (bus.out_pc !== p) $display("FAIL fen_pc[%0d] got %h want %h", k, bus.out_pc, p); else n_pass++;
            end else begin
                n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fen_drained got %b want 0", bus.out_valid); else n_pass++;
            end
            tick(); settle();
        end
        bus.fetch_en = 1'b1;
        settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fen_restart0 got %b want 0", bus.out_valid); else n_pass++;
        tick(); settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fen_restart1 got %b want 0", bus.out_valid); else n_pass++;
        tick(); settle();
        for (int i = 0; i < 3; i++) begin
            p = h + 16'd2 + addr_t'(i);
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL fen_resume_valid[%0d] got %b want 1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_pc !== p) $display("FAIL fen_resume_pc[%0d] got %h want %h", i, bus.out_pc, p); else n_pass++;
            tick(); settle();
        end
        exp_head = h + 16'd5;
    endtask

    // Redirect to the last address: FFFF then wrap to 0000, 0001.
    task automatic test_wrap();
        addr_t p;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        tick();
        bus.redirect_valid = 1'b0;
        tick(); tick(); settle();
        for (int i = 0; i < 3; i++) begin
            p = 16'hFFFF + addr_t'(i);
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL wrap_valid[%0d] got %b want 1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_pc !== p) $display("FAIL wrap_pc[%0d] got %h want %h", i, bus.out_pc, p); else n_pass++;
            n_checks++; if (bus.out_instr !== 32'h1000_0000 + {16'h0, p}) $display("FAIL wrap_instr[%0d] got %h want %h", i, bus.out_instr, 32'h1000_0000 + {16'h0, p}); else n_pass++;
            tick(); settle();
        end
    endtask

    // One-cycle reset with a full queue: everything dropped, restart from pc 0.
    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        tick(); settle();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rmid_full_valid got %b want 1", bus.out_valid); else n_pass++;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b1;
        settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.mem_a !== 16'h0000) $display("FAIL rmid_mem_a got %h want 0000", bus.mem_a); else n_pass++;
        tick(); settle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_valid_n1 got %b want 0", bus.out_valid); else n_pass++;
        tick(); settle();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rmid_out_valid[%0d] got %b want 1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_pc !== addr_t'(i)) $display("FAIL rmid_pc[%0d] got %h want %h", i, bus.out_pc, addr_t'(i)); else n_pass++;
            tick(); settle();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        exp_head = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_b2b();
        test_fetch_en();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
